// File: rtl/rf_multiport_sb.sv
// rtl/rf_multiport_sb.sv - multi-port register file with static write priority, bypass, R0 and scoreboard
module rf_multiport_sb #(
  parameter int XLEN    = 32,
  parameter int AW      = 3,
  parameter int NRP     = 4,
  parameter int NWP     = 3,
  parameter int FW      = 5,
  parameter bit BYPASS  = 1'b0,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                  CLK,
  input  logic                  N_RST,
  input  logic [NRP*AW-1:0]     RA,
  output logic [NRP*XLEN-1:0]   RD,
  output logic [NRP-1:0]        RBUSY,
  input  logic [NWP*AW-1:0]     WA,
  input  logic [NWP*XLEN-1:0]   WD,
  input  logic [NWP-1:0]        WE,
  input  logic                  RSV_EN,
  input  logic [AW-1:0]         RSV_A,
  output logic [(1<<AW)-1:0]    BUSY,
  input  logic [NWP*FW-1:0]     WDF,
  input  logic [NWP-1:0]        WEF,
  output logic [FW-1:0]         FLAGS,
  output logic                  WCOLL
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] wen;
  logic [XLEN-1:0] wdat [NREG];
  logic            coll;
  logic [FW-1:0]   flags_nxt;
  logic [AW-1:0]   ra;

  // Ports scanned high index to low so the lowest-index hit is the last (winning) assignment;
  // any earlier hit on the same register means two ports collided.
  always_comb begin
    wen  = '0;
    coll = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      wdat[r] = '0;
      for (int p = NWP - 1; p >= 0; p--) begin
        if (WE[p] && (WA[p*AW +: AW] == AW'(r)) && !(ZERO_R0 && (r == 0))) begin
          if (wen[r]) coll = 1'b1;
          wen[r]  = 1'b1;
          wdat[r] = WD[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    flags_nxt = FLAGS;
    for (int p = NWP - 1; p >= 0; p--) begin
      if (WEF[p]) flags_nxt = WDF[p*FW +: FW];
    end
  end

  always_comb begin
    RD    = '0;
    RBUSY = '0;
    ra    = '0;
    for (int i = 0; i < NRP; i++) begin
      ra                   = RA[i*AW +: AW];
      RD[i*XLEN +: XLEN]   = regs[ra];
      RBUSY[i]             = BUSY[ra];
      if (BYPASS && wen[ra]) RD[i*XLEN +: XLEN] = wdat[ra];
      if (ZERO_R0 && (ra == '0)) begin
        RD[i*XLEN +: XLEN] = '0;
        RBUSY[i]           = 1'b0;
      end
    end
  end

  // A reserve in the same cycle as a write hands ownership to the new producer, so set beats clear.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      BUSY  <= '0;
      FLAGS <= '0;
      WCOLL <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wen[r]) regs[r] <= wdat[r];
        if (RSV_EN && (RSV_A == AW'(r)) && !(ZERO_R0 && (r == 0)))
          BUSY[r] <= 1'b1;
        else if (wen[r])
          BUSY[r] <= 1'b0;
      end
      FLAGS <= flags_nxt;
      WCOLL <= coll;
    end
  end

endmodule
